// File: rtl/debounce_strobe.sv
// Raw asynchronous input conditioner: two-flop synchronizer, clock-enable
// prescaler and a four-state debounce FSM producing a clean level plus strobes.
module debounce_strobe #(
    parameter int unsigned PRESCALE = 16,
    parameter int unsigned COUNT    = 4,
    parameter logic        INIT     = 1'b0
) (
    input  logic C,
    input  logic CLR,
    input  logic CE,
    input  logic D,
    output logic Q,
    output logic RISE,
    output logic FALL,
    output logic TICK
);
    localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]    CNT_LAST   = 8'(COUNT - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    localparam state_t RESET_STATE = INIT ? STABLE_HIGH : STABLE_LOW;

    logic          s1_q, s2_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [7:0]    cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic          q_q, q_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Prescaler advances only on CE; the wrap edge schedules one TICK cycle.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (CE) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // A new level is accepted after COUNT consecutive disagreeing ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick_q) begin
            case (state_q)
                STABLE_LOW: begin
                    if (s2_q) begin
                        if (COUNT == 1) begin
                            q_d     = 1'b1;
                            rise_d  = 1'b1;
                            state_d = STABLE_HIGH;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = CHECK_HIGH;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                CHECK_HIGH: begin
                    if (!s2_q) begin
                        state_d = STABLE_LOW;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        q_d     = 1'b1;
                        rise_d  = 1'b1;
                        state_d = STABLE_HIGH;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                STABLE_HIGH: begin
                    if (!s2_q) begin
                        if (COUNT == 1) begin
                            q_d     = 1'b0;
                            fall_d  = 1'b1;
                            state_d = STABLE_LOW;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = CHECK_LOW;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                CHECK_LOW: begin
                    if (s2_q) begin
                        state_d = STABLE_HIGH;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        q_d     = 1'b0;
                        fall_d  = 1'b1;
                        state_d = STABLE_LOW;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = RESET_STATE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            s1_q    <= INIT;
            s2_q    <= INIT;
            presc_q <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= 8'd0;
            state_q <= RESET_STATE;
            q_q     <= INIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= D;
            s2_q    <= s1_q;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign Q    = q_q;
    assign RISE = rise_q;
    assign FALL = fall_q;
    assign TICK = tick_q;
endmodule

// File: tb/tb_debounce_strobe.sv
// Two debounce_strobe instances (4/3/INIT=0 and 1/1/INIT=1) share directed and
// random stimulus; a level/run-length reference model feeds a scoreboard.
module tb_debounce_strobe;
    logic clk = 1'b0;
    logic CLR, CE, D;
    logic q_a, rise_a, fall_a, tick_a;
    logic q_b, rise_b, fall_b, tick_b;

    always #5 clk = ~clk;

    debounce_strobe #(.PRESCALE(4), .COUNT(3), .INIT(1'b0)) dut_a (
        .C(clk), .CLR(CLR), .CE(CE), .D(D),
        .Q(q_a), .RISE(rise_a), .FALL(fall_a), .TICK(tick_a)
    );
    debounce_strobe #(.PRESCALE(1), .COUNT(1), .INIT(1'b1)) dut_b (
        .C(clk), .CLR(CLR), .CE(CE), .D(D),
        .Q(q_b), .RISE(rise_b), .FALL(fall_b), .TICK(tick_b)
    );

    int   m_pre  [2] = '{4, 1};
    int   m_cnt  [2] = '{3, 1};
    bit   m_init [2] = '{1'b0, 1'b1};

    // Reference model: D seen two edges late, tick every m_pre CE-high edges,
    // level flips after m_cnt consecutive ticks that disagree with it.
    bit [1:0] dhist   [2];
    int       ce_seen [2];
    bit       tick    [2];
    bit       lvl     [2];
    int       run     [2];
    bit       rise    [2];
    bit       fall    [2];

    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s t=%0t got {Q,RISE,FALL,TICK}=%b expected %b", name, $time, got, expv);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            dhist[i]   = {m_init[i], m_init[i]};
            ce_seen[i] = 0;
            tick[i]    = 1'b0;
            lvl[i]     = m_init[i];
            run[i]     = 0;
            rise[i]    = 1'b0;
            fall[i]    = 1'b0;
        end
    endtask

    task automatic model_edge(input bit d, input bit ce);
        for (int i = 0; i < 2; i++) begin
            bit seen;
            seen    = dhist[i][1];
            rise[i] = 1'b0;
            fall[i] = 1'b0;
            if (tick[i]) begin
                if (seen != lvl[i]) begin
                    run[i]++;
                    if (run[i] == m_cnt[i]) begin
                        lvl[i]  = seen;
                        rise[i] = seen;
                        fall[i] = !seen;
                        run[i]  = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            tick[i] = ce && (((ce_seen[i] + 1) % m_pre[i]) == 0);
            if (ce) ce_seen[i] = (ce_seen[i] + 1) % m_pre[i];
            dhist[i] = {dhist[i][0], d};
            if (i == 0) exp_a.push_back({lvl[i], rise[i], fall[i], tick[i]});
            else        exp_b.push_back({lvl[i], rise[i], fall[i], tick[i]});
        end
    endtask

    // Monitor: every posedge, compare the outputs against the queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_a.size() > 0) check("scb_a", {q_a, rise_a, fall_a, tick_a}, exp_a.pop_front());
            if (exp_b.size() > 0) check("scb_b", {q_b, rise_b, fall_b, tick_b}, exp_b.pop_front());
        end
    end

    // Called at a negedge; inputs apply to the next posedge.
    task automatic step(input bit d, input bit ce);
        D  = d;
        CE = ce;
        model_edge(d, ce);
        @(negedge clk);
    endtask

    task automatic hold(input bit d, input bit ce, input int n);
        repeat (n) step(d, ce);
    endtask

    // Mid-cycle asynchronous reset; the edge before it is modelled normally.
    task automatic do_reset();
        model_edge(D, CE);
        @(posedge clk);
        #3;
        CLR = 1'b1;
        #1;
        check("rst_async_a", {q_a, rise_a, fall_a, tick_a}, {m_init[0], 3'b000});
        check("rst_async_b", {q_b, rise_b, fall_b, tick_b}, {m_init[1], 3'b000});
        model_reset();
        @(negedge clk);
        CLR = 1'b0;
    endtask

    initial begin
        CLR = 1'b1;
        D   = 1'b0;
        CE  = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_init_a", {q_a, rise_a, fall_a, tick_a}, {m_init[0], 3'b000});
        check("rst_init_b", {q_b, rise_b, fall_b, tick_b}, {m_init[1], 3'b000});
        CLR = 1'b0;

        // Clean steps up and down.
        hold(1'b0, 1'b1, 20);
        hold(1'b1, 1'b1, 30);
        hold(1'b0, 1'b1, 30);
        // Short glitch.
        hold(1'b1, 1'b1, 6);
        hold(1'b0, 1'b1, 30);
        // Bounce then settle high.
        for (int k = 0; k < 14; k++) hold(k[0] == 1'b0, 1'b1, 3);
        hold(1'b1, 1'b1, 30);
        // CE held low during a qualification window.
        hold(1'b0, 1'b1, 30);
        hold(1'b1, 1'b1, 8);
        hold(1'b1, 1'b0, 50);
        hold(1'b1, 1'b1, 30);
        // Reset while instance B is presenting RISE.
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 2);
        do_reset();
        // Reset in the middle of a check, then full requalification.
        hold(1'b0, 1'b1, 20);
        hold(1'b1, 1'b1, 7);
        do_reset();
        hold(1'b1, 1'b1, 30);

        // Random segments with occasional CE drops and resets.
        for (int s = 0; s < 250; s++) begin
            bit d;
            int len;
            d   = $urandom_range(0, 1) == 1;
            len = $urandom_range(1, 16);
            for (int c = 0; c < len; c++) step(d, $urandom_range(0, 7) != 0);
            if ($urandom_range(0, 24) == 0) do_reset();
        end
        hold(D, 1'b1, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
